// File: rtl/fir_feeder.sv
// fir_feeder: serial coefficient loader and cadence-locked sample feeder
// for the FIR block, with a ready/valid result register.
module fir_feeder #(
  parameter int X_N_SIZE      = 8,
  parameter int TAP_SIZE      = 3,
  parameter int NBR_OF_TAPS   = 3,
  parameter int Y_N_SIZE      = 11,
  parameter int FIFO_DEPTH    = 4,
  parameter int SAMPLE_PERIOD = NBR_OF_TAPS + 3,
  parameter int INIT_WAIT     = 5
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cfg_start,
  input  logic [NBR_OF_TAPS*TAP_SIZE-1:0] cfg_coeffs,
  output logic                            cfg_done,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [X_N_SIZE-1:0]             s_data,
  output logic [X_N_SIZE-1:0]             fir_x_n,
  output logic                            fir_tvalid,
  output logic                            fir_set_coeffs,
  input  logic [Y_N_SIZE-1:0]             fir_y_n,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [Y_N_SIZE-1:0]             m_data,
  output logic                            overrun,
  output logic                            busy
);

  localparam int TW      = NBR_OF_TAPS * TAP_SIZE;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CFG_LEN = NBR_OF_TAPS + 2;
  localparam int CMAX0   = (INIT_WAIT > SAMPLE_PERIOD) ?
                           INIT_WAIT : SAMPLE_PERIOD;
  localparam int CMAX    = (CMAX0 > CFG_LEN) ? CMAX0 : CFG_LEN;
  localparam int CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] CFG_LAST  = CW'(CFG_LEN - 1);
  localparam logic [CW-1:0] PH_LAST   = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] N_TAPS    = CW'(NBR_OF_TAPS);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CFG,
    S_START,
    S_STREAM
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                cfg_pending_q, cfg_pending_d;
  logic                pend_q, pend_d;
  logic [TW-1:0]       taps_q, taps_d;
  logic [X_N_SIZE-1:0] x_n_q, x_n_d;
  logic                m_valid_q, m_valid_d;
  logic [Y_N_SIZE-1:0] m_data_q, m_data_d;
  logic                overrun_q, overrun_d;
  logic                cfg_done_q, cfg_done_d;

  logic [X_N_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [X_N_SIZE-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;

  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                capture;
  logic [X_N_SIZE-1:0] head;
  logic [TAP_SIZE-1:0] tap_sel;
  int                  tap_idx;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign s_ready = !full && (state_q != S_INIT);
  assign push    = s_valid && s_ready;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = s_data;
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // The FIR shift path wants the last tap twice before walking down.
  always_comb begin
    if (cnt_q == '0) begin
      tap_idx = NBR_OF_TAPS - 1;
    end else begin
      tap_idx = NBR_OF_TAPS - int'(cnt_q);
    end
    tap_sel = '0;
    for (int k = 0; k < NBR_OF_TAPS; k++) begin
      if (tap_idx == k) begin
        tap_sel = taps_q[k*TAP_SIZE +: TAP_SIZE];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cfg_pending_d  = cfg_pending_q;
    pend_d         = pend_q;
    taps_d         = taps_q;
    x_n_d          = x_n_q;
    m_valid_d      = m_valid_q && !m_ready;
    m_data_d       = m_data_q;
    overrun_d      = overrun_q;
    cfg_done_d     = 1'b0;
    fir_tvalid     = 1'b0;
    fir_set_coeffs = 1'b0;
    pop            = 1'b0;
    capture        = 1'b0;

    if (cfg_start && (state_q != S_CFG)) begin
      cfg_pending_d = 1'b1;
    end

    unique case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cfg_pending_q) begin
          state_d = S_CFG;
          cnt_d   = '0;
          taps_d  = cfg_coeffs;
        end else if (!empty) begin
          state_d = S_START;
        end
      end
      S_CFG: begin
        fir_set_coeffs = (cnt_q < N_TAPS);
        if (cnt_q <= N_TAPS) begin
          x_n_d = X_N_SIZE'(tap_sel);
        end else begin
          x_n_d = '0;
        end
        if (cnt_q == CFG_LAST) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          cfg_done_d    = 1'b1;
          cfg_pending_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        fir_tvalid = 1'b1;
        state_d    = S_STREAM;
        cnt_d      = '0;
      end
      S_STREAM: begin
        fir_tvalid = 1'b1;
        cnt_d      = (cnt_q == PH_LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == '0) begin
          capture = pend_q;
          pend_d  = 1'b0;
          if (!empty && !cfg_pending_q) begin
            pop    = 1'b1;
            x_n_d  = head;
            pend_d = 1'b1;
          end else begin
            fir_tvalid = 1'b0;
            x_n_d      = '0;
            state_d    = S_IDLE;
            cnt_d      = '0;
          end
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    // Capture while still unread loses the old value.
    if (capture) begin
      m_data_d  = fir_y_n;
      m_valid_d = 1'b1;
      if (m_valid_q && !m_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      cfg_pending_q <= 1'b0;
      pend_q        <= 1'b0;
      taps_q        <= '0;
      x_n_q         <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      overrun_q     <= 1'b0;
      cfg_done_q    <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_pending_q <= cfg_pending_d;
      pend_q        <= pend_d;
      taps_q        <= taps_d;
      x_n_q         <= x_n_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      overrun_q     <= overrun_d;
      cfg_done_q    <= cfg_done_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  assign fir_x_n  = x_n_d;
  assign cfg_done = cfg_done_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: directed bench with a behavioural FIR and a result
// scoreboard filled at sample push time.
module tb_fir_feeder;

  localparam int XW = 8;
  localparam int TW = 3;
  localparam int NT = 3;
  localparam int YW = 11;
  localparam int SP = NT + 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_start;
  logic [NT*TW-1:0]  cfg_coeffs;
  logic              cfg_done;
  logic              s_valid;
  logic              s_ready;
  logic [XW-1:0]     s_data;
  logic [XW-1:0]     fir_x_n;
  logic              fir_tvalid;
  logic              fir_set_coeffs;
  logic [YW-1:0]     fir_y_n;
  logic              m_valid;
  logic              m_ready;
  logic [YW-1:0]     m_data;
  logic              overrun;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  // 0x1D1 splits into taps 1, 2, -1 (tap 0 = newest sample)
  int tap [NT] = '{1, 2, -1};
  int sw_h [NT];
  int sbq [$];

  int f_h [NT];
  int f_y;
  logic f_run;
  int f_ph;

  always #5 clk = ~clk;

  fir_feeder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_coeffs     (cfg_coeffs),
    .cfg_done       (cfg_done),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs),
    .fir_y_n        (fir_y_n),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .overrun        (overrun),
    .busy           (busy)
  );

  // FIR: capture at the sample slot, result out on the period's last cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_run   <= 1'b0;
      f_ph    <= 0;
      f_y     <= 0;
      fir_y_n <= '0;
      f_h     <= '{default: 0};
    end else if (!fir_tvalid) begin
      f_run <= 1'b0;
    end else if (!f_run) begin
      f_run <= 1'b1;
      f_ph  <= 0;
    end else begin
      if (f_ph == 0) begin
        f_h[0] <= $signed(fir_x_n);
        f_h[1] <= f_h[0];
        f_h[2] <= f_h[1];
        f_y    <= tap[0] * $signed(fir_x_n) +
                  tap[1] * f_h[0] + tap[2] * f_h[1];
      end
      if (f_ph == SP - 1) begin
        fir_y_n <= YW'(f_y);
      end
      f_ph <= (f_ph == SP - 1) ? 0 : f_ph + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void sb_push(input logic [XW-1:0] d);
    sw_h[2] = sw_h[1];
    sw_h[1] = sw_h[0];
    sw_h[0] = $signed(d);
    sbq.push_back(tap[0]*sw_h[0] + tap[1]*sw_h[1] + tap[2]*sw_h[2]);
  endfunction

  task automatic tick();
    logic          pu;
    logic          tk;
    logic [XW-1:0] sd;
    logic [YW-1:0] md;
    pu = s_valid && s_ready;
    sd = s_data;
    tk = m_valid && m_ready;
    md = m_data;
    @(posedge clk);
    #1;
    if (pu) sb_push(sd);
    if (tk) begin
      chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        chk("m_data", 32'(md), 32'(YW'(sbq.pop_front())));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_x [5] = '{7, 7, 2, 1, 0};

  initial begin
    reset_n    = 1'b0;
    cfg_start  = 1'b0;
    cfg_coeffs = 9'h1D1;
    s_valid    = 1'b1;
    s_data     = 8'd0;
    m_ready    = 1'b1;
    sw_h       = '{default: 0};

    // reset and INIT window
    @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_tvalid", 32'(fir_tvalid), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("init_s_ready", 32'(s_ready), 0);
      chk("init_busy", 32'(busy), 1);
      chk("init_x_n", 32'(fir_x_n), 0);
      chk("init_setc", 32'(fir_set_coeffs), 0);
      tick();
    end
    chk("idle_s_ready", 32'(s_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_overrun", 32'(overrun), 0);
    chk("idle_cfg_done", 32'(cfg_done), 0);
    s_valid = 1'b0;

    // coefficient load
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("cfgreq_busy", 32'(busy), 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("cfg_x_n", 32'(fir_x_n), 32'(exp_x[c]));
      chk("cfg_setc", 32'(fir_set_coeffs), 32'(c < 3));
      chk("cfg_tvalid", 32'(fir_tvalid), 0);
      chk("cfg_done_lo", 32'(cfg_done), 0);
      tick();
    end
    chk("cfg_done_hi", 32'(cfg_done), 1);
    chk("cfg_end_busy", 32'(busy), 0);
    tick();
    chk("cfg_done_pulse", 32'(cfg_done), 0);

    // stream 10, 20, 30
    s_valid = 1'b1;
    s_data  = 8'd10;
    tick();
    s_data = 8'd20;
    tick();
    s_data = 8'd30;
    tick();
    s_valid = 1'b0;
    chk("slot0_x_n", 32'(fir_x_n), 10);
    chk("slot0_tvalid", 32'(fir_tvalid), 1);
    run(3);
    chk("hold_x_n", 32'(fir_x_n), 10);
    run(3);
    chk("slot1_x_n", 32'(fir_x_n), 20);
    chk("slot1_m_valid", 32'(m_valid), 0);
    tick();
    chk("lat_m_valid", 32'(m_valid), 1);
    chk("lat_m_data", 32'(m_data), 10);
    run(5);
    chk("slot2_x_n", 32'(fir_x_n), 30);
    run(6);
    chk("term_tvalid", 32'(fir_tvalid), 0);
    chk("term_x_n", 32'(fir_x_n), 0);
    tick();
    chk("term_busy", 32'(busy), 0);
    chk("term_m_data", 32'(m_data), 60);
    tick();
    chk("sb_drain1", 32'(sbq.size()), 0);

    // backpressure across two results
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'd40;
    tick();
    s_data = 8'd50;
    tick();
    s_valid = 1'b0;
    run(8);
    chk("bp_m_valid", 32'(m_valid), 1);
    chk("bp_no_ovr", 32'(overrun), 0);
    run(6);
    chk("bp_m_data", 32'(m_data), 100);
    chk("bp_overrun", 32'(overrun), 1);
    chk("bp_sb_size", 32'(sbq.size()), 2);
    void'(sbq.pop_front());
    m_ready = 1'b1;
    tick();
    chk("bp_ovr_sticky", 32'(overrun), 1);
    chk("bp_m_valid_clr", 32'(m_valid), 0);

    // config request mid-stream
    s_valid = 1'b1;
    s_data  = 8'd60;
    tick();
    s_data = 8'd70;
    tick();
    s_data = 8'd80;
    tick();
    s_valid = 1'b0;
    chk("mid_slot_x_n", 32'(fir_x_n), 60);
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run(4);
    chk("mid_term_tvalid", 32'(fir_tvalid), 0);
    chk("mid_term_x_n", 32'(fir_x_n), 0);
    tick();
    chk("mid_idle_busy", 32'(busy), 0);
    chk("mid_idle_setc", 32'(fir_set_coeffs), 0);
    tick();
    chk("mid_cfg_setc", 32'(fir_set_coeffs), 1);
    chk("mid_cfg_x_n", 32'(fir_x_n), 7);
    run(7);
    chk("mid_resume_x_n", 32'(fir_x_n), 70);
    chk("mid_resume_tv", 32'(fir_tvalid), 1);
    run(12);
    chk("mid_end_tvalid", 32'(fir_tvalid), 0);
    run(2);
    chk("sb_drain2", 32'(sbq.size()), 0);

    // fill the FIFO while CFG holds it, then reset mid-stream
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = XW'(i + 1);
      chk("fill_s_ready", 32'(s_ready), 1);
      tick();
    end
    chk("full_s_ready", 32'(s_ready), 0);
    s_data = 8'd99;
    tick();
    chk("full_hold", 32'(s_ready), 0);
    s_valid = 1'b0;
    run(2);
    chk("full_slot_x_n", 32'(fir_x_n), 1);
    tick();
    chk("full_popped", 32'(s_ready), 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("ares_tvalid", 32'(fir_tvalid), 0);
    chk("ares_x_n", 32'(fir_x_n), 0);
    chk("ares_busy", 32'(busy), 1);
    chk("ares_s_ready", 32'(s_ready), 0);
    chk("ares_overrun", 32'(overrun), 0);
    chk("ares_m_valid", 32'(m_valid), 0);
    sbq.delete();
    sw_h = '{default: 0};
    reset_n = 1'b1;
    run(5);
    chk("post_busy", 32'(busy), 0);
    chk("post_s_ready", 32'(s_ready), 1);
    run(3);
    chk("post_empty", 32'(busy), 0);
    chk("post_tvalid", 32'(fir_tvalid), 0);
    chk("post_m_valid", 32'(m_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_feeder.md
# fir_feeder

Stream-side driver for the FIR filter block: loads the filter coefficients over the FIR's serial coefficient path and feeds buffered input samples at the FIR's fixed sample cadence. It also captures each filtered result into a ready/valid output register. It sits between the sample source and the FIR and owns the FIR's `x_n`, `s_axis_fir_tvalid` and `s_set_coeffs` inputs.

## Interface
- `X_N_SIZE`, 8, sample width
- `TAP_SIZE`, 3, coefficient width
- `NBR_OF_TAPS`, 3, number of coefficients
- `Y_N_SIZE`, 11, FIR result width
- `FIFO_DEPTH`, 4, input FIFO entries (power of two, ≥2)
- `SAMPLE_PERIOD`, `NBR_OF_TAPS+3`, FIR cycles per sample (1 capture + `NBR_OF_TAPS+1` multiply-accumulate + 1 output)
- `INIT_WAIT`, 5, cycles after reset before the FIR is assumed idle
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cfg_start`  in  1  one-cycle request to load `cfg_coeffs`
- `cfg_coeffs`  in  `NBR_OF_TAPS*TAP_SIZE`  tap k at bits `[k*TAP_SIZE +: TAP_SIZE]`; tap 0 weights the newest sample
- `cfg_done`  out  1  one-cycle pulse when the load completes
- `s_valid` / `s_ready` / `s_data`  in/out/in  1/1/`X_N_SIZE`  sample input handshake
- `fir_x_n`  out  `X_N_SIZE`  to FIR `x_n`
- `fir_tvalid`  out  1  to FIR `s_axis_fir_tvalid`
- `fir_set_coeffs`  out  1  to FIR `s_set_coeffs`
- `fir_y_n`  in  `Y_N_SIZE`  from FIR `o_y_n`
- `m_valid` / `m_ready` / `m_data`  out/in/out  1/1/`Y_N_SIZE`  result output handshake
- `overrun`  out  1  sticky; set when an unread result is overwritten
- `busy`  out  1  high in every state except IDLE

## Operation
- FIFO: push on `s_valid & s_ready`; `s_ready = !full`. Pop happens only at a sample slot. A push and a pop in the same cycle are both legal. Pointers wrap modulo `FIFO_DEPTH`.
- `cfg_start` sets a `cfg_pending` flag in any state except CFG, where it is ignored. `cfg_coeffs` is latched into an internal register on the cycle CFG is entered.
- States and transitions:
  - INIT: counts `INIT_WAIT` cycles, then goes to IDLE.
  - IDLE: goes to CFG if `cfg_pending`. Otherwise goes to START if the FIFO is non-empty. CFG has priority.
  - CFG: lasts `NBR_OF_TAPS+2` cycles, indexed c = 0..`NBR_OF_TAPS+1`.
    - `fir_set_coeffs` = 1 for c < `NBR_OF_TAPS`, else 0.
    - For c ≤ `NBR_OF_TAPS`, `fir_x_n[TAP_SIZE-1:0]` = tap[`NBR_OF_TAPS` − max(c,1)], with upper bits 0. For c = `NBR_OF_TAPS+1`, `fir_x_n` = 0.
    - At the end, pulse `cfg_done`, clear `cfg_pending`, go to IDLE.
  - START: one cycle, `fir_tvalid` = 1. Goes to STREAM with phase = 0.
  - STREAM: phase counter runs 0..`SAMPLE_PERIOD`−1 and wraps; phase 0 is the sample slot. `fir_tvalid` = 1 at every phase except a terminating slot.
- At each slot:
  - If `pending_result` is set, capture `fir_y_n` into `m_data`, set `m_valid`, and clear `pending_result`.
  - If the FIFO is non-empty and `cfg_pending` = 0: pop, drive `fir_x_n` = head, and set `pending_result`.
  - Otherwise this is a terminating slot: `fir_tvalid` = 0, `fir_x_n` = 0, no pop, go to IDLE.
- `fir_x_n` holds its value between slots. `fir_set_coeffs` is never 1 while `fir_tvalid` is 1.
- A config request during STREAM ends the session at the next slot; IDLE then enters CFG the following cycle.
- Results are signed. `fir_y_n` is captured unmodified, with no rounding or shifting.
- Output register:
  - `m_valid` clears on `m_ready`.
  - A capture while `m_valid & !m_ready` overwrites `m_data` and sets `overrun`.
  - A capture in the same cycle as `m_ready` is not an overrun; `m_valid` stays 1.
  - `overrun` clears only on reset.

## Timing
- Reset values: state INIT, FIFO empty, `s_ready` 0 during INIT and 1 after, all other outputs 0, `cfg_pending` 0, `pending_result` 0.
- Sample latency: a sample driven at slot cycle t yields its result captured at t+`SAMPLE_PERIOD`, with `m_valid` visible from t+`SAMPLE_PERIOD`+1.
- The first slot comes 2 cycles after leaving IDLE, 3 cycles after the first FIFO push.
- Steady-state throughput is one sample per `SAMPLE_PERIOD` cycles. At the default parameters the FIFO fills if the source pushes faster than that.
- CFG occupies exactly `NBR_OF_TAPS+2` cycles (5 at default).
- `reset_n` assertion mid-operation immediately returns the block to INIT and empties the FIFO. Any in-flight result is dropped.

## Test plan
- Reset/INIT: deassert `reset_n` with `s_valid` = 1 → `s_ready` = 0 for 5 cycles, all FIR outputs 0, `busy` = 1; IDLE follows with `busy` = 0.
- Coefficient load: `cfg_coeffs` = 0x1D1 (taps 1, 2, −1) → `fir_set_coeffs` high for 3 cycles; `fir_x_n` = 7, 7, 2, 1, 0; then a `cfg_done` pulse.
- Stream: after the load, push 10, 20, 30 back to back → slots 6 cycles apart; `m_data` = 10, 40, 60 from the FIR model; a terminating slot with `fir_tvalid` = 0 follows.
- Backpressure: hold `m_ready` = 0 across two results → `m_data` equals the second result and `overrun` = 1. `overrun` persists after `m_ready` = 1.
- Mid-stream config: `cfg_start` while samples remain → the next slot terminates with no pop, CFG starts the following cycle, and the remaining samples stream afterward.
- Full FIFO and async reset: push 4 samples in 4 cycles → `s_ready` = 0 when full. Asserting `reset_n` low mid-STREAM → outputs 0 immediately and the FIFO is empty afterward.
